// File: rtl/mem_access_unit_if.sv
// Physical memory bus between mem_access_unit and the memory model.
//   master (mem_access_unit): drives pmem_read/pmem_write strobes, word address,
//          lane-shifted write data and byte enables; receives pmem_rdata/pmem_resp.
//   slave  (memory): the reverse direction.
// Handshake: exactly one of pmem_read/pmem_write is held high, together with
// constant address/data/mask, until the memory answers with a one-cycle
// pmem_resp (read data valid in that same cycle); the strobe drops the next edge.
interface mem_access_unit_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access stage between the multicycle RV32I datapath/control and
// physical memory. One word-aligned request at a time; misaligned accesses are
// rejected without touching memory; a stuck request is aborted after TIMEOUT
// cycles. Load data is returned shifted down to byte lane 0.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_read/write    level requests from control, sampled only in IDLE
//   fetch, funct3     access size (fetch forces word)
//   addr, wdata       byte address (MAR) and right-justified store data
//   rdata             last successfully loaded word, lane-0 aligned
//   done, err         one-cycle completion pulse and its error flag
//   fsm_state         current FSM state (0 IDLE, 1 BUSY, 2 DONE) for debug
//   pmem              physical memory bus (master side)
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              fetch,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic [1:0]        fsm_state,
    mem_access_unit_if.master pmem
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;

    // Request decode (only meaningful in IDLE)
    logic       is_byte, is_half, misaligned;
    logic [3:0] store_mask;

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (!fetch) begin
            case (funct3)
                3'b000, 3'b100: is_byte = 1'b1;
                3'b001, 3'b101: is_half = 1'b1;
                default: ;  // 010 and unused codes behave as word
            endcase
        end
    end

    assign misaligned = is_byte ? 1'b0 :
                        is_half ? addr[0] :
                                  (addr[1:0] != 2'b00);
    assign store_mask = is_byte ? (4'b0001 << addr[1:0]) :
                        is_half ? (4'b0011 << addr[1:0]) :
                                  4'b1111;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 16'd0;
                        addr_d  = {addr[31:2], 2'b00};
                        off_d   = addr[1:0];
                        wdata_d = wdata << {addr[1:0], 3'b000};
                        // Read wins when both requests are high
                        rd_d    = req_read;
                        wr_d    = !req_read;
                        be_d    = req_read ? 4'b1111 : store_mask;
                    end
                end
            end
            BUSY: begin
                if (pmem.pmem_resp) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = 1'b1;
                    if (rd_q) begin
                        rdata_d = pmem.pmem_rdata >> {off_q, 3'b000};
                    end
                end else if (cnt_q == LAST_CNT) begin
                    // Counter starts at 0 on entry, so the strobe has been
                    // high for exactly TIMEOUT cycles here
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
        end
    end

    assign rdata                 = rdata_q;
    assign done                  = done_q;
    assign err                   = err_q;
    assign fsm_state             = state_q;
    assign pmem.pmem_read        = rd_q;
    assign pmem.pmem_write       = wr_q;
    assign pmem.pmem_address     = addr_q;
    assign pmem.pmem_wdata       = wdata_q;
    assign pmem.pmem_byte_enable = be_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage between the multicycle RV32I datapath/control and physical memory. It takes the datapath's MAR address and data-out register value, plus read/write requests from the control FSM. It issues one word-aligned request at a time with byte enables and lane-shifted write data, and holds it until `pmem_resp` or a timeout. It returns the loaded word shifted down to byte lane 0, so the datapath's MDR extension logic (lb/lbu/lh/lhu taken from the low bits) works unchanged. It reports completion to control as a one-cycle `done` pulse.

## Interface
- `TIMEOUT`, 255: maximum cycles in BUSY before the request is aborted; legal range 1..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_read`  in  1  control requests a read; level, sampled only in IDLE.
- `req_write`  in  1  control requests a write; level, sampled only in IDLE.
- `fetch`  in  1  read is an instruction fetch; forces word size regardless of `funct3`.
- `funct3`  in  3  load/store size code (rv32i encodings: 000 b, 001 h, 010 w, 100 bu, 101 hu).
- `addr`  in  32  byte address (from MAR).
- `wdata`  in  32  store data, right-justified (from data-out register).
- `rdata`  out  32  read word shifted right by 8*addr[1:0]; zero-filled above; held until next successful read.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned access or timeout.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  32  {addr[31:2], 2'b00}.
- `pmem_wdata`  out  32  wdata shifted left by 8*addr[1:0].
- `pmem_byte_enable`  out  4  active-high lane mask.
- `pmem_rdata`  in  32  memory read data, valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion, one cycle.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:**
  - No request: stay in IDLE, all strobes 0.
  - Request present: resolve `req_read` over `req_write` if both are high; the write is dropped.
  - Size: `fetch`=1 forces word.
  - Misaligned accesses: half with addr[0]=1, or word with addr[1:0]≠0.
  - Misaligned → go to DONE with err=1; no pmem strobe; `rdata` unchanged.
  - Aligned → register address, mask, shifted data and direction; go to BUSY; clear timeout counter.
- **Byte enable:**
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word and all reads: 4'b1111.
  - funct3 011/110/111: treated as word.
- **BUSY:**
  - Strobe (`pmem_read` xor `pmem_write`) and the registered address/data/mask are held constant.
  - Counter increments each cycle.
  - `pmem_resp`=1 → drop strobe next edge; on a read, capture `pmem_rdata>>(8*off)` into `rdata`; go to DONE with err=0.
  - `pmem_resp` has priority over timeout in the same cycle.
  - Counter reaches TIMEOUT−1 without resp → drop strobe; go to DONE with err=1; `rdata` unchanged.
- **DONE:**
  - `done`=1 for exactly this cycle; `err` is as set on entry.
  - Always return to IDLE.
  - A request still asserted in the following IDLE cycle starts a new access; control must drop `req_*` on seeing `done`.
- `pmem_resp` outside BUSY is ignored.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `rdata`=0, `done`=0, `err`=0.
  - `pmem_read`=0, `pmem_write`=0.
  - `pmem_address`=0, `pmem_wdata`=0, `pmem_byte_enable`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Request sampled at edge N (IDLE) → strobe high from cycle N+1.
- Response cycle M → strobe low and `done`=1 in cycle M+1.
- Minimum accepted-to-done latency: 2 cycles (resp in first BUSY cycle).
- Misaligned: `done` asserted the cycle after the request is sampled; strobes never rise.
- Timeout: strobe is high for exactly TIMEOUT cycles, then `done`/`err` appear the next cycle.
- `rst` in any state: next edge forces reset values; an in-flight memory transaction is abandoned and no `done` is produced.
- Back-to-back requests: at most one access every 3 cycles (IDLE→BUSY→DONE).

## Test plan
- **Aligned LW:** req_read, funct3=010, addr=0x1000; resp after 3 cycles with pmem_rdata=0xDEADBEEF → pmem_address=0x1000, mask 1111, strobe high for 3 cycles; then done=1, err=0, rdata=0xDEADBEEF.
- **Byte store:** SB at addr=0x2003, wdata=0x000000A5 → pmem_address=0x2000, mask 1000, pmem_wdata=0xA5000000, pmem_write=1 until resp. Half load: LH at addr=0x2002 with pmem_rdata=0x8001_1234 → rdata=0x00008001.
- **Misaligned:** SW at addr=0x3002 → no strobe; done and err=1 one cycle later; rdata unchanged. Same for LHU at 0x3001. fetch=1 with funct3=000 at 0x3001 → err.
- **Timeout:** TIMEOUT=4, read with pmem_resp held 0 → pmem_read high exactly 4 cycles, then done=1, err=1; a late pmem_resp is ignored.
- **Reset and simultaneous requests:** rst asserted in BUSY → next cycle strobes 0, state IDLE, no done. req_read and req_write both high → only pmem_read asserted.
